// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and sizing helpers for the chunked serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk operation still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int width, input int chunk);
        int nch;
        nch = width / chunk;
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// With SERIAL_ADDER_OVF_EN defined it also exports the carry into the MSB.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             c_msb
`endif
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[CHUNK];

`ifdef SERIAL_ADDER_OVF_EN
    assign c_msb = w_c[CHUNK-1];
`endif

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH   = calc_nch(WIDTH, CHUNK);
    localparam int CNT_W = calc_cnt_w(WIDTH, CHUNK);

    state_e             r_state;
    state_e             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;
    logic [CHUNK-1:0]   w_sum;
    logic               w_carry_out;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic               w_c_msb;
    logic               r_ovf;
`endif

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .c_msb(w_c_msb)
`endif
    );

    assign w_last     = (r_cnt == CNT_W'(NCH - 1));
    // Chunk results enter at the top and walk down, so the LSB chunk ends at bit 0.
    assign w_res_next = (r_res >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = RUN;
            end
            RUN: begin
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_res   <= w_res_next;
                    r_carry <= w_carry_out;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Outputs are loaded only here so they stay frozen while out_valid is high.
                    if (w_last) begin
                        r_s    <= w_res_next;
                        r_cout <= w_carry_out;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf  <= w_c_msb ^ w_carry_out;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock.
- Carry is held in a register between chunks.
- Next generation of the 1-bit full-adder cell: replaces wide combinational ripple with a small, area-cheap datapath.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: s=a+b+cin; 1: s=a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out (for sub: 1 = no borrow).

Behaviour:
- Reset is the only reset path: one clock and one reset, synchronous and active-high.
- While rst=1 at a rising edge, the next state is:
  - state=IDLE; in_ready=1; out_valid=0; s=0; cout=0.
  - Operand registers, carry register and chunk counter are all 0.
- Constant NCH = WIDTH/CHUNK. Counter width = clog2(NCH), minimum 1.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load A_reg=a; B_reg = sub ? ~b : b; carry = sub ? 1 : cin. Clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: add A_reg[CHUNK-1:0] + B_reg[CHUNK-1:0] + carry with a combinational CHUNK-bit ripple adder.
  - Store the chunk result in the top CHUNK bits of the result shift register, which shifts right by CHUNK.
  - Shift A_reg and B_reg right by CHUNK. carry <= chunk carry-out. counter++.
  - On counter==NCH-1: go to DONE, registering the final carry into cout.
- DONE:
  - out_valid=1. s and cout are held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_valid is ignored in DONE. There is no overlap: a new accept happens at earliest the cycle after the output handshake.
- Latency: operands accepted at edge T give out_valid=1 from edge T+NCH (4 cycles at defaults).
  - Throughput: one result per NCH+2 cycles when out_ready is held high.
- Output stability: s and cout change only on entry to DONE or on reset, never while out_valid=1.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full sum.
- sub=1 computes a + ~b + 1. cin is ignored.
- CHUNK==WIDTH is legal: RUN lasts one cycle.
- Reset asserted in RUN or DONE aborts the operation: no out_valid is produced and the block returns to IDLE next cycle.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), which is the two's-complement signed overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured in the final RUN cycle.
  - ovf is valid with out_valid and resets to 0.
- Undefined: no ovf port and no MSB-carry tracking logic.

Decomposition:
- Package serial_adder_pkg holds:
  - State encoding typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function computing NCH and counter width from WIDTH/CHUNK.
- One sub-module, add_chunk (parameter CHUNK):
  - Combinational CHUNK-bit ripple adder built from full-adder cells.
  - Ports: s, cout, a, b, cin.
  - Also exports the carry into the MSB, for the ovf option.

Test Plan (WIDTH=16, CHUNK=4):
- Reset: hold rst for 2 cycles -> in_ready=1, out_valid=0, s=16'h0000, cout=0.
- Basic add: a=16'h1234, b=16'h4321, cin=0, sub=0 -> s=16'h5555, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- Full carry chain: a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1. Then a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored) -> s=16'hFFFE, cout=0. Then a=16'h0007, b=16'h0005 -> s=16'h0002, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
  - Expect s and out_valid held stable, in_ready=0, and no second accept.
  - After out_ready=1: IDLE, then the new operands are accepted.
- Abort and overflow:
  - Assert rst for 1 cycle, 2 cycles into RUN -> IDLE next cycle, out_valid never asserted.
  - With SERIAL_ADDER_OVF_EN defined: a=16'h7FFF, b=16'h0001 -> s=16'h8000, ovf=1, cout=0.
